// File: rtl/asteroids_stage_controller_pkg.sv
// Shared types for the asteroid special-stage controller.
package asteroids_stage_controller_pkg;

  // Stage sequencer states; also exported on the controller's debug port.
  typedef enum logic [2:0] {
    IDLE,
    INTRO,
    ACTIVE,
    CLEARED,
    DONE
  } stage_state_t;

endpackage

// File: rtl/asteroids_stage_controller_frame_phase_counter.sv
// Counts video frames within the current phase and flags the frame pulse
// that completes a phase of `limit` frames.
module asteroids_stage_controller_frame_phase_counter #(
  parameter int FRAME_CNT_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       clear,
  input  logic                       startOfFrame,
  input  logic [FRAME_CNT_WIDTH-1:0] limit,
  output logic                       phase_done
);

  logic [FRAME_CNT_WIDTH-1:0] frameCnt;

  // Frame counter: restarts whenever the owner changes phase, else counts frames.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameCnt <= '0;
    end else if (clear) begin
      frameCnt <= '0;
    end else if (startOfFrame) begin
      frameCnt <= frameCnt + 1'b1;
    end
  end

  // A phase of N frames ends on the Nth frame pulse (count already at N-1).
  assign phase_done = startOfFrame && (frameCnt == (limit - 1'b1));

endmodule

// File: rtl/asteroids_stage_controller.sv
// Asteroid special-stage sequencer: runs WAVES waves of INTRO -> ACTIVE ->
// CLEARED, ending in DONE on success or on an ACTIVE-phase frame timeout.
// Handshake note: all inputs are single-clock pulses or levels sampled on
// clk; there is no backpressure, every pulse is consumed the clock it is seen.
module asteroids_stage_controller
  import asteroids_stage_controller_pkg::*;
#(
  parameter int INTRO_FRAMES    = 60,
  parameter int CLEAR_FRAMES    = 30,
  parameter int TIMEOUT_FRAMES  = 900,
  parameter int WAVES           = 3,
  parameter int FRAME_CNT_WIDTH = 10,
  parameter int KILL_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  start_stage,
  input  logic                  abort,
  input  logic                  all_asteroids_destroied,
  input  logic                  asteroid_exploded_pulse,
  output logic                  asteroids_enable,
  output logic                  asteroids_resetN,
  output logic [3:0]            wave_number,
  output logic [KILL_WIDTH-1:0] kill_count,
  output logic                  stage_done_pulse,
  output logic                  stage_timeout,
  output stage_state_t          debugState
);

  stage_state_t               state;
  stage_state_t               nextState;
  logic [FRAME_CNT_WIDTH-1:0] phaseLimit;
  logic                       phaseDone;
  logic                       stateChange;
  logic                       lastWave;
  logic                       startAccepted;
  logic                       killCountable;

  assign lastWave      = (wave_number == 4'(WAVES - 1));
  assign startAccepted = start_stage && ((state == IDLE) || (state == DONE));
  assign killCountable = (state == ACTIVE) || (state == CLEARED);
  assign stateChange   = (nextState != state);
  assign debugState    = state;

  // Phase length for whichever state is currently timing frames.
  always_comb begin
    phaseLimit = FRAME_CNT_WIDTH'(TIMEOUT_FRAMES);
    case (state)
      INTRO:   phaseLimit = FRAME_CNT_WIDTH'(INTRO_FRAMES);
      CLEARED: phaseLimit = FRAME_CNT_WIDTH'(CLEAR_FRAMES);
      default: phaseLimit = FRAME_CNT_WIDTH'(TIMEOUT_FRAMES);
    endcase
  end

  asteroids_stage_controller_frame_phase_counter #(
    .FRAME_CNT_WIDTH(FRAME_CNT_WIDTH)
  ) u_phase_counter (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (stateChange),
    .startOfFrame(startOfFrame),
    .limit       (phaseLimit),
    .phase_done  (phaseDone)
  );

  // Next-state logic; abort overrides everything, clearing beats timeout.
  always_comb begin
    nextState = state;
    if (abort) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stage) nextState = INTRO;
        INTRO:   if (phaseDone) nextState = ACTIVE;
        ACTIVE: begin
          if (all_asteroids_destroied) nextState = CLEARED;
          else if (phaseDone)          nextState = DONE;
        end
        CLEARED: if (phaseDone) nextState = lastWave ? DONE : INTRO;
        DONE:    if (start_stage) nextState = INTRO;
        default: nextState = IDLE;
      endcase
    end
  end

  // State register plus registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= IDLE;
      asteroids_enable <= 1'b0;
      asteroids_resetN <= 1'b0;
      stage_done_pulse <= 1'b0;
      wave_number      <= '0;
      kill_count       <= '0;
      stage_timeout    <= 1'b0;
    end else begin
      state            <= nextState;
      asteroids_enable <= (nextState == ACTIVE) || (nextState == CLEARED);
      asteroids_resetN <= (nextState != IDLE) && (nextState != INTRO);
      stage_done_pulse <= (nextState == DONE) && (state != DONE);
      if (abort || startAccepted) begin
        wave_number   <= '0;
        kill_count    <= '0;
        stage_timeout <= 1'b0;
      end else begin
        if ((state == CLEARED) && phaseDone && !lastWave) begin
          wave_number <= wave_number + 1'b1;
        end
        if ((state == ACTIVE) && !all_asteroids_destroied && phaseDone) begin
          stage_timeout <= 1'b1;
        end
        // Explosions while the field is held in reset are spurious; ignore them.
        if (killCountable && asteroid_exploded_pulse && (kill_count != '1)) begin
          kill_count <= kill_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_asteroids_stage_controller.sv
// Directed bench for the asteroid stage controller with short frame phases.
module tb_asteroids_stage_controller;
  import asteroids_stage_controller_pkg::*;

  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic          start_stage;
  logic          abort;
  logic          all_asteroids_destroied;
  logic          asteroid_exploded_pulse;
  logic          asteroids_enable;
  logic          asteroids_resetN;
  logic [3:0]    wave_number;
  logic [KW-1:0] kill_count;
  logic          stage_done_pulse;
  logic          stage_timeout;
  stage_state_t  debugState;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  asteroids_stage_controller #(
    .INTRO_FRAMES   (2),
    .CLEAR_FRAMES   (3),
    .TIMEOUT_FRAMES (5),
    .WAVES          (2),
    .FRAME_CNT_WIDTH(10),
    .KILL_WIDTH     (KW)
  ) dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (startOfFrame),
    .start_stage            (start_stage),
    .abort                  (abort),
    .all_asteroids_destroied(all_asteroids_destroied),
    .asteroid_exploded_pulse(asteroid_exploded_pulse),
    .asteroids_enable       (asteroids_enable),
    .asteroids_resetN       (asteroids_resetN),
    .wave_number            (wave_number),
    .kill_count             (kill_count),
    .stage_done_pulse       (stage_done_pulse),
    .stage_timeout          (stage_timeout),
    .debugState             (debugState)
  );

  // Clock generation
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic startPulse();
    start_stage = 1'b1;
    tick();
    start_stage = 1'b0;
  endtask

  task automatic explode();
    asteroid_exploded_pulse = 1'b1;
    tick();
    asteroid_exploded_pulse = 1'b0;
  endtask

  task automatic clearWave();
    all_asteroids_destroied = 1'b1;
    tick();
    all_asteroids_destroied = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    chk({tag, "_state"}, debugState, IDLE);
    chk({tag, "_en"}, asteroids_enable, 0);
    chk({tag, "_aresetN"}, asteroids_resetN, 0);
    chk({tag, "_wave"}, wave_number, 0);
    chk({tag, "_kill"}, kill_count, 0);
    chk({tag, "_donePulse"}, stage_done_pulse, 0);
    chk({tag, "_timeout"}, stage_timeout, 0);
  endtask

  initial begin
    // Reset
    resetN = 1'b0;
    startOfFrame = 1'b0;
    start_stage = 1'b0;
    abort = 1'b0;
    all_asteroids_destroied = 1'b0;
    asteroid_exploded_pulse = 1'b0;
    tick();
    tick();
    checkIdleOutputs("rst");
    resetN = 1'b1;
    tick();

    // Normal two-wave run
    startPulse();
    chk("run_intro_state", debugState, INTRO);
    chk("run_intro_aresetN", asteroids_resetN, 0);
    chk("run_intro_en", asteroids_enable, 0);
    for (int i = 0; i < 3; i++) explode();
    chk("intro_kill_masked", kill_count, 0);
    frame();
    chk("intro_after1", debugState, INTRO);
    frame();
    chk("active_state", debugState, ACTIVE);
    chk("active_aresetN", asteroids_resetN, 1);
    chk("active_en", asteroids_enable, 1);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back((i + 1 > 7) ? 7 : i + 1);
      explode();
      chk("kill_sat", kill_count, exp_q.pop_front());
    end
    clearWave();
    chk("cleared_state", debugState, CLEARED);
    chk("cleared_en", asteroids_enable, 1);
    frames(2);
    chk("cleared_after2", debugState, CLEARED);
    frame();
    chk("wave1_intro", debugState, INTRO);
    chk("wave1_num", wave_number, 1);
    chk("wave1_aresetN", asteroids_resetN, 0);
    chk("wave1_en", asteroids_enable, 0);
    frames(2);
    chk("wave1_active", debugState, ACTIVE);
    clearWave();
    explode();
    chk("kill_held_sat", kill_count, 7);
    frames(2);
    chk("no_pulse_before_done", stage_done_pulse, 0);
    frame();
    chk("done_state", debugState, DONE);
    chk("done_pulse", stage_done_pulse, 1);
    chk("done_timeout", stage_timeout, 0);
    chk("done_wave", wave_number, 1);
    chk("done_en", asteroids_enable, 0);
    tick();
    chk("done_pulse_once", stage_done_pulse, 0);
    chk("done_hold", debugState, DONE);
    chk("done_kill_hold", kill_count, 7);

    // Restart from DONE, time out on wave 1
    startPulse();
    chk("restart_state", debugState, INTRO);
    chk("restart_wave", wave_number, 0);
    chk("restart_kill", kill_count, 0);
    frames(2);
    clearWave();
    frames(3);
    chk("to_wave1", wave_number, 1);
    frames(2);
    chk("to_active", debugState, ACTIVE);
    frames(4);
    chk("to_before", debugState, ACTIVE);
    frame();
    chk("to_done", debugState, DONE);
    chk("to_timeout", stage_timeout, 1);
    chk("to_wave_hold", wave_number, 1);
    chk("to_pulse", stage_done_pulse, 1);

    // Clear coinciding with the timeout frame: clearing wins
    startPulse();
    chk("sim_timeout_cleared", stage_timeout, 0);
    frames(2);
    frames(4);
    all_asteroids_destroied = 1'b1;
    startOfFrame = 1'b1;
    tick();
    all_asteroids_destroied = 1'b0;
    startOfFrame = 1'b0;
    chk("sim_state", debugState, CLEARED);
    chk("sim_timeout", stage_timeout, 0);
    chk("sim_pulse", stage_done_pulse, 0);
    frames(3);
    chk("sim_wave1", wave_number, 1);
    frames(2);
    clearWave();
    frame();
    chk("abort_pre_state", debugState, CLEARED);

    // Abort from CLEARED on wave 1
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkIdleOutputs("abort");
    frames(3);
    chk("idle_ignores_frames", debugState, IDLE);

    // Asynchronous reset in the middle of ACTIVE
    startPulse();
    frames(2);
    explode();
    chk("arst_pre_kill", kill_count, 1);
    chk("arst_pre_en", asteroids_enable, 1);
    resetN = 1'b0;
    #2;
    checkIdleOutputs("arst");
    resetN = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
